alu_issue_ctrl: RTL and testbench

Upstream command issuer for the unsigned 16-bit ALU. Accepts operand/opcode commands over a valid/ready handshake, buffers them in a small FIFO, drives the ALU's A, B and ALU_FUN inputs one command at a time, and captures the ALU's registered result and flags into an output register with its own valid/ready handshake. The block keeps at most one command in flight, which preserves result ordering. Division by zero can optionally be trapped before the command reaches the ALU.

---
 rtl/alu_issue_pkg.sv | 24 ++
 rtl/alu_issue_ctrl_fifo.sv | 36 +++
 rtl/alu_issue_ctrl.sv | 116 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: opcodes, flag bit positions and FSM states shared by the ALU command issuer
package alu_issue_pkg;
    localparam logic [3:0] FUN_ADD  = 4'b0000;
    localparam logic [3:0] FUN_SUB  = 4'b0001;
    localparam logic [3:0] FUN_MUL  = 4'b0010;
    localparam logic [3:0] FUN_DIV  = 4'b0011;
    localparam logic [3:0] FUN_AND  = 4'b0100;
    localparam logic [3:0] FUN_OR   = 4'b0101;
    localparam logic [3:0] FUN_NAND = 4'b0110;
    localparam logic [3:0] FUN_NOR  = 4'b0111;
    localparam logic [3:0] FUN_XOR  = 4'b1000;
    localparam logic [3:0] FUN_XNOR = 4'b1001;
    localparam logic [3:0] FUN_CMPEQ = 4'b1010;
    localparam logic [3:0] FUN_CMPGT = 4'b1011;
    localparam logic [3:0] FUN_CMPLT = 4'b1100;
    localparam logic [3:0] FUN_SHR  = 4'b1101;
    localparam logic [3:0] FUN_SHL  = 4'b1110;
    localparam logic [3:0] FUN_NOP  = 4'b1111;
    localparam int FLAG_ARITH = 3;
    localparam int FLAG_LOGIC = 2;
    localparam int FLAG_CMP   = 1;
    localparam int FLAG_SHIFT = 0;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;
endpackage

// File: rtl/alu_issue_ctrl_fifo.sv
// alu_cmd_fifo: show-ahead command FIFO with registered count and async reset
module alu_cmd_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_data,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    assign o_data  = r_mem[r_rptr];
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    // storage needs no reset: only entries below the count are ever read
    always_ff @(posedge i_clk)
        if (i_push) r_mem[r_wptr] <= i_data;
    // pointers wrap modulo DEPTH for free because DEPTH is a power of two
    always_ff @(posedge i_clk or posedge i_rst)
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop) r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, i_push} - {{AW{1'b0}}, i_pop};
        end
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: buffers ALU commands, issues one at a time and holds each result; DIV0_TRAP_EN traps divide-by-zero
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic [DATA_W-1:0] CMD_A,
    input  logic [DATA_W-1:0] CMD_B,
    input  logic [3:0]        CMD_FUN,
    output logic [DATA_W-1:0] ALU_A,
    output logic [DATA_W-1:0] ALU_B,
    output logic [3:0]        ALU_FUN,
    input  logic [DATA_W-1:0] ALU_OUT,
    input  logic [3:0]        ALU_FLAGS,
    output logic              RES_VALID,
    input  logic              RES_READY,
    output logic [DATA_W-1:0] RES_DATA,
    output logic [3:0]        RES_FLAGS,
    output logic              RES_ERR
);
    localparam int CW = 2*DATA_W+4;
    state_t            r_state, w_next;
    logic              w_full, w_empty, w_push, w_pop, w_accept, w_div0;
    logic [CW-1:0]     w_head;
    logic [DATA_W-1:0] w_head_a, w_head_b;
    logic [3:0]        w_head_fun;
    logic [DATA_W-1:0] r_alu_a, r_alu_b, r_res_data;
    logic [3:0]        r_alu_fun, r_res_flags;
    assign {w_head_a, w_head_b, w_head_fun} = w_head;
    assign CMD_READY = !w_full && !RST;
    assign w_push    = CMD_VALID && CMD_READY;
    assign RES_VALID = r_state == HOLD;
    assign w_accept  = RES_VALID && RES_READY;
    assign ALU_A     = r_alu_a;
    assign ALU_B     = r_alu_b;
    assign ALU_FUN   = r_alu_fun;
    assign RES_DATA  = r_res_data;
    assign RES_FLAGS = r_res_flags;

    alu_cmd_fifo #(.W(CW), .DEPTH(DEPTH)) u_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_push  (w_push),
        .i_data  ({CMD_A, CMD_B, CMD_FUN}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef DIV0_TRAP_EN
    logic r_res_err;
    assign w_div0  = w_head_fun == FUN_DIV && w_head_b == '0;
    assign RES_ERR = r_res_err;
    // error bit follows whichever path produced the held result
    always_ff @(posedge CLK or posedge RST)
        if (RST) r_res_err <= 1'b0;
        else if (r_state == CAPTURE) r_res_err <= 1'b0;
        else if (w_pop && w_div0) r_res_err <= 1'b1;
`else
    assign w_div0  = 1'b0;
    assign RES_ERR = 1'b0;
`endif

    // state register
    always_ff @(posedge CLK or posedge RST)
        if (RST) r_state <= IDLE;
        else r_state <= w_next;

    // pop from IDLE, or from HOLD in the same cycle the held result leaves
    always_comb begin
        w_pop  = !w_empty && (r_state == IDLE || (r_state == HOLD && w_accept));
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_pop ? (w_div0 ? HOLD : ISSUE) : IDLE;
            ISSUE:   w_next = CAPTURE;
            CAPTURE: w_next = HOLD;
            HOLD:    w_next = !w_accept ? HOLD : w_pop ? (w_div0 ? HOLD : ISSUE) : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ALU drive: load a non-trapped command on pop, fall back to NOP once its result is captured
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_fun <= FUN_NOP;
        end else if (w_pop && !w_div0) begin
            r_alu_a   <= w_head_a;
            r_alu_b   <= w_head_b;
            r_alu_fun <= w_head_fun;
        end else if (r_state == CAPTURE) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_fun <= FUN_NOP;
        end

    // result register: written only on capture or trap, so it stays stable throughout HOLD
    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            r_res_data  <= '0;
            r_res_flags <= '0;
        end else if (r_state == CAPTURE) begin
            r_res_data  <= ALU_OUT;
            r_res_flags <= ALU_FLAGS;
        end else if (w_pop && w_div0) begin
            r_res_data  <= '1;
            r_res_flags <= 4'(1 << FLAG_ARITH);
        end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl with a behavioural registered ALU
module tb_alu_issue_ctrl;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [15:0] CMD_A = '0, CMD_B = '0;
    logic [3:0]  CMD_FUN = '0;
    logic [15:0] ALU_A, ALU_B;
    logic [3:0]  ALU_FUN;
    logic [15:0] ALU_OUT = '0;
    logic [3:0]  ALU_FLAGS = '0;
    logic        RES_VALID;
    logic        RES_READY = 1'b0;
    logic [15:0] RES_DATA;
    logic [3:0]  RES_FLAGS;
    logic        RES_ERR;

    int n_checks = 0;
    int n_pass = 0;
    logic [20:0] exp_q[$];
    logic [20:0] e;
    logic watch = 1'b0;
    logic saw_issue = 1'b0;

    alu_issue_ctrl #(.DATA_W(16), .DEPTH(4)) dut (
        .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_FUN(CMD_FUN),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
        .ALU_OUT(ALU_OUT), .ALU_FLAGS(ALU_FLAGS),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY),
        .RES_DATA(RES_DATA), .RES_FLAGS(RES_FLAGS), .RES_ERR(RES_ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [19:0] alu_model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
        case (f)
            4'b0000: return {4'b1000, a + b};
            4'b0001: return {4'b1000, a - b};
            4'b0010: return {4'b1000, a * b};
            4'b0011: return {4'b1000, (b == 16'd0) ? 16'd0 : a / b};
            4'b0100: return {4'b0100, a & b};
            4'b0101: return {4'b0100, a | b};
            4'b0110: return {4'b0100, ~(a & b)};
            4'b0111: return {4'b0100, ~(a | b)};
            4'b1000: return {4'b0100, a ^ b};
            4'b1001: return {4'b0100, ~(a ^ b)};
            4'b1010: return {4'b0010, (a == b) ? 16'd1 : 16'd0};
            4'b1011: return {4'b0010, (a > b) ? 16'd2 : 16'd0};
            4'b1100: return {4'b0010, (a < b) ? 16'd3 : 16'd0};
            4'b1101: return {4'b0001, a >> 1};
            4'b1110: return {4'b0001, a << 1};
            default: return 20'h0;
        endcase
    endfunction

    always @(posedge CLK) {ALU_FLAGS, ALU_OUT} <= alu_model(ALU_A, ALU_B, ALU_FUN);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    always @(negedge CLK) begin
        if (watch && ALU_FUN != 4'b1111) saw_issue = 1'b1;
        if (!RST && RES_VALID && RES_READY) begin
            if (exp_q.size() == 0) chk("unexpected_result", 32'(RES_DATA), 32'hFFFF_FFFF);
            else begin
                e = exp_q.pop_front();
                chk("res_data", 32'(RES_DATA), 32'(e[20:5]));
                chk("res_flags", 32'(RES_FLAGS), 32'(e[4:1]));
                chk("res_err", 32'(RES_ERR), 32'(e[0]));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                        input logic [15:0] ed, input logic [3:0] ef, input logic ee);
        int n;
        n = 0;
        CMD_A = a;
        CMD_B = b;
        CMD_FUN = f;
        CMD_VALID = 1'b1;
        while (!CMD_READY && n < 50) begin
            tick(1);
            n++;
        end
        chk("cmd_accept", 32'(CMD_READY), 32'd1);
        exp_q.push_back({ed, ef, ee});
        tick(1);
        CMD_VALID = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || RES_VALID) && n < 200) begin
            tick(1);
            n++;
        end
        chk("drain_done", 32'(n < 200), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        tick(2);
        chk("ready_in_reset", 32'(CMD_READY), 32'd0);
        RST = 1'b0;
        #1;
        chk("rst_ready", 32'(CMD_READY), 32'd1);
        chk("rst_alu_a", 32'(ALU_A), 32'd0);
        chk("rst_alu_b", 32'(ALU_B), 32'd0);
        chk("rst_alu_fun", 32'(ALU_FUN), 32'hF);
        chk("rst_res_valid", 32'(RES_VALID), 32'd0);
        chk("rst_res_data", 32'(RES_DATA), 32'd0);
        chk("rst_res_flags", 32'(RES_FLAGS), 32'd0);
        chk("rst_res_err", 32'(RES_ERR), 32'd0);

        send(16'd5, 16'd3, 4'b0000, 16'd8, 4'b1000, 1'b0);
        tick(2);
        chk("latency_t2", 32'(RES_VALID), 32'd0);
        tick(1);
        chk("latency_t3", 32'(RES_VALID), 32'd1);
        RES_READY = 1'b1;
        drain();

        RES_READY = 1'b0;
        send(16'd1, 16'd2, 4'b0000, 16'd3, 4'b1000, 1'b0);
        send(16'd10, 16'd20, 4'b0000, 16'd30, 4'b1000, 1'b0);
        send(16'd100, 16'd1, 4'b0000, 16'd101, 4'b1000, 1'b0);
        send(16'h1234, 16'h1111, 4'b0000, 16'h2345, 4'b1000, 1'b0);
        chk("ready_three_queued", 32'(CMD_READY), 32'd1);
        send(16'd7, 16'd8, 4'b0000, 16'd15, 4'b1000, 1'b0);
        chk("ready_full", 32'(CMD_READY), 32'd0);
        tick(5);
        chk("hold_ready_full", 32'(CMD_READY), 32'd0);
        chk("hold_valid", 32'(RES_VALID), 32'd1);
        chk("hold_stable_data", 32'(RES_DATA), 32'd3);
        RES_READY = 1'b1;
        drain();
        chk("ready_after_drain", 32'(CMD_READY), 32'd1);

        send(16'h8001, 16'd0, 4'b1110, 16'h0002, 4'b0001, 1'b0);
        send(16'h8001, 16'd0, 4'b1101, 16'h4000, 4'b0001, 1'b0);
        drain();

        saw_issue = 1'b0;
        watch = 1'b1;
`ifdef DIV0_TRAP_EN
        send(16'd7, 16'd0, 4'b0011, 16'hFFFF, 4'b1000, 1'b1);
        drain();
        chk("div0_alu_issued", 32'(saw_issue), 32'd0);
`else
        send(16'd7, 16'd0, 4'b0011, 16'd0, 4'b1000, 1'b0);
        drain();
        chk("div0_alu_issued", 32'(saw_issue), 32'd1);
`endif
        watch = 1'b0;
        send(16'd100, 16'd7, 4'b0011, 16'd14, 4'b1000, 1'b0);
        drain();

        send(16'd9, 16'd9, 4'b1010, 16'd1, 4'b0010, 1'b0);
        send(16'd9, 16'd9, 4'b1111, 16'd0, 4'b0000, 1'b0);
        drain();

        RES_READY = 1'b0;
        send(16'h00AA, 16'd1, 4'b0000, 16'h00AB, 4'b1000, 1'b0);
        send(16'd2, 16'd2, 4'b0000, 16'd4, 4'b1000, 1'b0);
        send(16'd3, 16'd3, 4'b0000, 16'd6, 4'b1000, 1'b0);
        chk("capture_alu_a", 32'(ALU_A), 32'h00AA);
        chk("capture_not_valid", 32'(RES_VALID), 32'd0);
        RST = 1'b1;
        #1;
        exp_q.delete();
        chk("mid_rst_ready", 32'(CMD_READY), 32'd0);
        chk("mid_rst_alu_a", 32'(ALU_A), 32'd0);
        chk("mid_rst_alu_fun", 32'(ALU_FUN), 32'hF);
        chk("mid_rst_valid", 32'(RES_VALID), 32'd0);
        chk("mid_rst_data", 32'(RES_DATA), 32'd0);
        chk("mid_rst_flags", 32'(RES_FLAGS), 32'd0);
        tick(1);
        RST = 1'b0;
        RES_READY = 1'b1;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (RES_VALID) cnt++;
        end
        chk("no_valid_after_rst", 32'(cnt), 32'd0);
        chk("ready_after_rst", 32'(CMD_READY), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
